reg_trace_array: RTL and testbench
==================================

REG_TRACE_ARRAY -- requirements
Module: reg_trace_array

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 21, full register address width.
REQ-002 SHALL have parameter pBYTECNT_SIZE, default 7, byte-count width.
REQ-003 SHALL have parameter pBUFFER_SIZE, default 64, pattern/mask width in bits (multiple of 8, 8..128).
REQ-004 SHALL have parameter pMATCH_RULES, default 8, rule count (1..16).
REQ-005 SHALL have parameter pCOUNT_WIDTH, default 16, match-counter width (8..32, multiple of 8).
REQ-006 SHALL have port usb_clk, input, 1, the only clock.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports reg_address [pADDR_WIDTH-1:pBYTECNT_SIZE], reg_bytecnt [pBYTECNT_SIZE-1:0], write_data 8, reg_read 1, reg_write 1 and reg_addrvalid 1 as inputs, and read_data 8 as an output, forming the usb_reg_fe register bus.
REQ-009 SHALL have port I_match_pulse, input, pMATCH_RULES, one-cycle per-rule match strobes synchronous to usb_clk.
REQ-010 SHALL have port O_pattern_enable, output, pMATCH_RULES, live rule enables.
REQ-011 SHALL have ports O_trace_patterns and O_trace_masks, outputs, pMATCH_RULES*pBUFFER_SIZE each, live flattened patterns and masks, rule i at [i*pBUFFER_SIZE +: pBUFFER_SIZE].
REQ-012 SHALL have port O_commit_pulse, output, 1, high for one cycle when a commit takes effect.

Function
REQ-013 Register reads SHALL have one-cycle latency: read_data is valid on the cycle after reg_read && reg_addrvalid, and is 0 otherwise.
REQ-014 REG_RULE_SELECT (8 bits, R/W) SHALL index all per-rule registers.
REQ-015 Writes to REG_TRACE_PATTERN and REG_TRACE_MASK SHALL update only the shadow copy of the selected rule, one byte at [reg_bytecnt*8 +: 8].
REQ-016 Writes to REG_PATTERN_ENABLE SHALL update only the shadow enable.
REQ-017 Reads of REG_TRACE_PATTERN, REG_TRACE_MASK and REG_PATTERN_ENABLE SHALL return the shadow values.
REQ-018 Any write to REG_COMMIT SHALL copy every shadow into the live outputs on the next edge and assert O_commit_pulse for exactly that cycle.
REQ-019 A commit coinciding with a shadow write SHALL NOT happen, because the bus is serial; a commit issued back-to-back SHALL pulse O_commit_pulse on each commit.
REQ-020 If the rule select is >= pMATCH_RULES, per-rule writes SHALL be ignored and per-rule reads SHALL return 0.
REQ-021 Each rule counter SHALL increment on I_match_pulse[i] and saturate at 2^pCOUNT_WIDTH-1 with no wrap.
REQ-022 A write to REG_COUNT_CLEAR SHALL zero every counter whose bit is set in write_data (rules 0..7) or in byte 1 (rules 8..15).
REQ-023 When a clear and an increment occur in the same cycle, the clear SHALL win and the counter SHALL read 0.
REQ-024 A read of REG_TRACE_COUNT with reg_bytecnt==0 SHALL snapshot the selected counter, and bytes 0..pCOUNT_WIDTH/8-1 SHALL all be served from that snapshot so multi-byte reads are coherent.
REQ-025 Reads of REG_NUM_RULES SHALL return pMATCH_RULES, and reads of REG_PARAMS SHALL return pBUFFER_SIZE/8 in byte 0 and pCOUNT_WIDTH/8 in byte 1.
REQ-026 Unmapped addresses SHALL read 0 and ignore writes.

Reset
REQ-027 On reset_n low, asynchronously: live and shadow patterns SHALL be 0, masks all-ones, enables 0, rule select 0, counters and snapshot 0, O_commit_pulse 0, read_data 0.
REQ-028 A reset arriving mid multi-byte access SHALL discard the access, and the bus SHALL resume cleanly on the next access.

Configuration
REQ-029 With TRACE_COUNTERS_EN defined, the counters, the snapshot, REG_COUNT_CLEAR and REG_TRACE_COUNT SHALL be implemented.
REQ-030 Without TRACE_COUNTERS_EN, I_match_pulse SHALL be ignored, REG_TRACE_COUNT SHALL read 0, REG_COUNT_CLEAR writes SHALL be ignored, and no counter flops SHALL be inferred.

Structure
REQ-031 Register address codes (REG_RULE_SELECT, REG_COMMIT, REG_COUNT_CLEAR, REG_NUM_RULES, REG_PARAMS, REG_TRACE_PATTERN, REG_TRACE_MASK, REG_TRACE_COUNT, REG_PATTERN_ENABLE) SHALL live in the shared defines file.
REQ-032 A sub-module trace_match_counter SHALL implement one saturating counter with clear priority, instantiated per rule in a generate loop.

Verification
REQ-033 Select 2, write pattern bytes 0..7 = 0x11..0x88, no commit -> O_trace_patterns rule 2 stays 0 and readback returns 0x11..0x88; write REG_COMMIT -> live rule 2 = 0x8877665544332211 and O_commit_pulse high for 1 cycle.
REQ-034 With pCOUNT_WIDTH=16, 65537 pulses on rule 0 -> count reads 0xFFFF.
REQ-035 Clear bit 0 in the same cycle as pulse 0 -> count reads 0.
REQ-036 Read count byte 0 = 0x05, then 3 pulses, then read byte 1 -> bytes reflect the snapshot 0x0005, and a fresh read returns 0x0008.
REQ-037 Select 9 with pMATCH_RULES=8, then write a mask -> no change, and readback is 0.
REQ-038 Assert reset_n low mid-sequence -> all outputs take their reset values immediately without a clock edge; a build without TRACE_COUNTERS_EN -> count reads 0 after pulses.

Source files
------------

// File: rtl/reg_trace_array_pkg.sv
// rtl/reg_trace_array_pkg.sv - register address codes for the trace pattern array
package reg_trace_array_pkg;

  localparam int REG_RULE_SELECT    = 1;
  localparam int REG_COMMIT         = 2;
  localparam int REG_COUNT_CLEAR    = 3;
  localparam int REG_NUM_RULES      = 4;
  localparam int REG_PARAMS         = 5;
  localparam int REG_TRACE_PATTERN  = 6;
  localparam int REG_TRACE_MASK     = 7;
  localparam int REG_TRACE_COUNT    = 8;
  localparam int REG_PATTERN_ENABLE = 9;

  typedef logic [7:0] reg_byte_t;

endpackage

// File: rtl/reg_trace_array_counter.sv
// rtl/reg_trace_array_counter.sv - one saturating match counter; clear beats increment
module trace_match_counter #(
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc_i,
  input  logic                    clr_i,
  output logic [pCOUNT_WIDTH-1:0] count_o
);

  logic [pCOUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/reg_trace_array.sv
// rtl/reg_trace_array.sv - shadowed trace pattern/mask/enable registers with commit
// Match counters are built only when TRACE_COUNTERS_EN is defined.
module reg_trace_array
  import reg_trace_array_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pBUFFER_SIZE  = 64,
  parameter int pMATCH_RULES  = 8,
  parameter int pCOUNT_WIDTH  = 16
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_n,
  input  logic [pADDR_WIDTH-1:pBYTECNT_SIZE]   reg_address,
  input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  input  logic [7:0]                           write_data,
  output logic [7:0]                           read_data,
  input  logic                                 reg_read,
  input  logic                                 reg_write,
  input  logic                                 reg_addrvalid,
  input  logic [pMATCH_RULES-1:0]              I_match_pulse,
  output logic [pMATCH_RULES-1:0]              O_pattern_enable,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_patterns,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_masks,
  output logic                                 O_commit_pulse
);

  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int NB = pBUFFER_SIZE / 8;
  localparam int CB = pCOUNT_WIDTH / 8;

  logic [pMATCH_RULES-1:0][NB-1:0][7:0] sh_pat_q, sh_pat_d, sh_mask_q, sh_mask_d;
  logic [pMATCH_RULES-1:0][NB-1:0][7:0] live_pat_q, live_pat_d, live_mask_q, live_mask_d;
  logic [pMATCH_RULES-1:0] sh_en_q, sh_en_d, live_en_q, live_en_d;
  logic [7:0]              rule_sel_q, rule_sel_d;
  logic                    commit_pulse_q, commit_pulse_d;
  reg_byte_t               read_data_q, read_data_d;

  logic wr, rd, sel_ok;
  logic a_sel, a_commit, a_clear, a_num, a_params, a_pat, a_mask, a_cnt, a_en;

  assign wr       = reg_write && reg_addrvalid;
  assign rd       = reg_read && reg_addrvalid;
  assign sel_ok   = int'(rule_sel_q) < pMATCH_RULES;
  assign a_sel    = reg_address == AW'(REG_RULE_SELECT);
  assign a_commit = reg_address == AW'(REG_COMMIT);
  assign a_clear  = reg_address == AW'(REG_COUNT_CLEAR);
  assign a_num    = reg_address == AW'(REG_NUM_RULES);
  assign a_params = reg_address == AW'(REG_PARAMS);
  assign a_pat    = reg_address == AW'(REG_TRACE_PATTERN);
  assign a_mask   = reg_address == AW'(REG_TRACE_MASK);
  assign a_cnt    = reg_address == AW'(REG_TRACE_COUNT);
  assign a_en     = reg_address == AW'(REG_PATTERN_ENABLE);

`ifdef TRACE_COUNTERS_EN
  logic [pCOUNT_WIDTH-1:0] count_w [pMATCH_RULES];
  logic [pMATCH_RULES-1:0] clr_vec;
  logic [pCOUNT_WIDTH-1:0] snap_q, snap_d, sel_count;
  reg_byte_t               cnt_byte;

  for (genvar g = 0; g < pMATCH_RULES; g++) begin : g_cnt
    trace_match_counter #(.pCOUNT_WIDTH(pCOUNT_WIDTH)) u_cnt (
      .clk    (usb_clk),
      .rst_n  (reset_n),
      .inc_i  (I_match_pulse[g]),
      .clr_i  (clr_vec[g]),
      .count_o(count_w[g])
    );
  end

  always_comb begin
    clr_vec   = '0;
    sel_count = '0;
    for (int i = 0; i < pMATCH_RULES; i++) begin
      if (wr && a_clear && (int'(reg_bytecnt) == i / 8)) clr_vec[i] = write_data[i % 8];
      if (sel_ok && int'(rule_sel_q) == i) sel_count = count_w[i];
    end
    // Byte 0 both returns and latches the live count; higher bytes replay the latch.
    snap_d   = snap_q;
    cnt_byte = '0;
    if (int'(reg_bytecnt) == 0) begin
      cnt_byte = sel_count[7:0];
      if (rd && a_cnt) snap_d = sel_count;
    end
    for (int b = 1; b < CB; b++) begin
      if (int'(reg_bytecnt) == b) cnt_byte = snap_q[b*8 +: 8];
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) snap_q <= '0;
    else          snap_q <= snap_d;
  end
`else
  logic unused_match;
  assign unused_match = ^I_match_pulse;
`endif

  always_comb begin
    sh_pat_d       = sh_pat_q;
    sh_mask_d      = sh_mask_q;
    sh_en_d        = sh_en_q;
    live_pat_d     = live_pat_q;
    live_mask_d    = live_mask_q;
    live_en_d      = live_en_q;
    rule_sel_d     = rule_sel_q;
    commit_pulse_d = wr && a_commit;
    if (wr && a_sel) rule_sel_d = write_data;
    for (int i = 0; i < pMATCH_RULES; i++) begin
      if (wr && sel_ok && int'(rule_sel_q) == i) begin
        if (a_en) sh_en_d[i] = write_data[0];
        for (int b = 0; b < NB; b++) begin
          if (int'(reg_bytecnt) == b) begin
            if (a_pat)  sh_pat_d[i][b]  = write_data;
            if (a_mask) sh_mask_d[i][b] = write_data;
          end
        end
      end
    end
    if (wr && a_commit) begin
      live_pat_d  = sh_pat_q;
      live_mask_d = sh_mask_q;
      live_en_d   = sh_en_q;
    end
  end

  always_comb begin
    read_data_d = '0;
    if (rd) begin
      if (a_sel) read_data_d = rule_sel_q;
      if (a_num) read_data_d = 8'(pMATCH_RULES);
      if (a_params && int'(reg_bytecnt) == 0) read_data_d = 8'(NB);
      if (a_params && int'(reg_bytecnt) == 1) read_data_d = 8'(CB);
      for (int i = 0; i < pMATCH_RULES; i++) begin
        if (sel_ok && int'(rule_sel_q) == i) begin
          if (a_en && int'(reg_bytecnt) == 0) read_data_d = {7'b0, sh_en_q[i]};
          for (int b = 0; b < NB; b++) begin
            if (int'(reg_bytecnt) == b) begin
              if (a_pat)  read_data_d = sh_pat_q[i][b];
              if (a_mask) read_data_d = sh_mask_q[i][b];
            end
          end
        end
      end
`ifdef TRACE_COUNTERS_EN
      if (a_cnt) read_data_d = cnt_byte;
`endif
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_pat_q       <= '0;
      sh_mask_q      <= '1;
      sh_en_q        <= '0;
      live_pat_q     <= '0;
      live_mask_q    <= '1;
      live_en_q      <= '0;
      rule_sel_q     <= '0;
      commit_pulse_q <= 1'b0;
      read_data_q    <= '0;
    end else begin
      sh_pat_q       <= sh_pat_d;
      sh_mask_q      <= sh_mask_d;
      sh_en_q        <= sh_en_d;
      live_pat_q     <= live_pat_d;
      live_mask_q    <= live_mask_d;
      live_en_q      <= live_en_d;
      rule_sel_q     <= rule_sel_d;
      commit_pulse_q <= commit_pulse_d;
      read_data_q    <= read_data_d;
    end
  end

  assign read_data        = read_data_q;
  assign O_trace_patterns = live_pat_q;
  assign O_trace_masks    = live_mask_q;
  assign O_pattern_enable = live_en_q;
  assign O_commit_pulse   = commit_pulse_q;

endmodule

// File: tb/tb_reg_trace_array.sv
// tb/tb_reg_trace_array.sv - directed checks of shadow/commit, select bounds, counters, reset
module tb_reg_trace_array;
  import reg_trace_array_pkg::*;

  logic         usb_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [20:7]  reg_address = '0;
  logic [6:0]   reg_bytecnt = '0;
  logic [7:0]   write_data = '0;
  logic [7:0]   read_data;
  logic         reg_read = 1'b0;
  logic         reg_write = 1'b0;
  logic         reg_addrvalid = 1'b0;
  logic [7:0]   I_match_pulse = '0;
  logic [7:0]   O_pattern_enable;
  logic [511:0] O_trace_patterns;
  logic [511:0] O_trace_masks;
  logic         O_commit_pulse;

  int total = 0;
  int bad = 0;
  logic [7:0]   rdata;
  logic [511:0] exp_pat;

  reg_trace_array dut (
    .usb_clk(usb_clk), .reset_n(reset_n), .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt), .write_data(write_data), .read_data(read_data),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .I_match_pulse(I_match_pulse), .O_pattern_enable(O_pattern_enable),
    .O_trace_patterns(O_trace_patterns), .O_trace_masks(O_trace_masks),
    .O_commit_pulse(O_commit_pulse)
  );

  always #5 usb_clk = ~usb_clk;

  task automatic bus_write(input int code, input int bc, input logic [7:0] d);
    @(negedge usb_clk);
    reg_address = 14'(code); reg_bytecnt = 7'(bc); write_data = d;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    @(negedge usb_clk);
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic bus_read(input int code, input int bc, output logic [7:0] d);
    @(negedge usb_clk);
    reg_address = 14'(code); reg_bytecnt = 7'(bc);
    reg_read = 1'b1; reg_addrvalid = 1'b1;
    @(negedge usb_clk);
    d = read_data;
    reg_read = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic pulse(input int rule, input int n);
    @(negedge usb_clk);
    I_match_pulse = 8'(1 << rule);
    repeat (n) @(negedge usb_clk);
    I_match_pulse = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge usb_clk);
    total++; if (O_trace_patterns !== '0) begin bad++; $display("FAIL reset_patterns got=%h exp=0", O_trace_patterns); end
    total++; if (O_trace_masks !== {512{1'b1}}) begin bad++; $display("FAIL reset_masks got=%h exp=all ones", O_trace_masks); end
    total++; if (O_pattern_enable !== 8'h00) begin bad++; $display("FAIL reset_enable got=%h exp=00", O_pattern_enable); end
    total++; if (O_commit_pulse !== 1'b0) begin bad++; $display("FAIL reset_commit got=%b exp=0", O_commit_pulse); end
    total++; if (read_data !== 8'h00) begin bad++; $display("FAIL reset_read_data got=%h exp=00", read_data); end
    reset_n = 1'b1;
    bus_read(REG_RULE_SELECT, 0, rdata);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rule_select got=%h exp=00", rdata); end
  endtask

  task automatic test_params();
    bus_read(REG_NUM_RULES, 0, rdata);
    total++; if (rdata !== 8'd8) begin bad++; $display("FAIL num_rules got=%h exp=08", rdata); end
    bus_read(REG_PARAMS, 0, rdata);
    total++; if (rdata !== 8'd8) begin bad++; $display("FAIL params_b0 got=%h exp=08", rdata); end
    bus_read(REG_PARAMS, 1, rdata);
    total++; if (rdata !== 8'd2) begin bad++; $display("FAIL params_b1 got=%h exp=02", rdata); end
  endtask

  task automatic test_shadow_commit();
    bus_write(REG_RULE_SELECT, 0, 8'd2);
    for (int b = 0; b < 8; b++) bus_write(REG_TRACE_PATTERN, b, 8'(8'h11 * (b + 1)));
    total++; if (O_trace_patterns[128 +: 64] !== 64'h0) begin bad++; $display("FAIL shadow_not_live got=%h exp=0", O_trace_patterns[128 +: 64]); end
    for (int b = 0; b < 8; b++) begin
      bus_read(REG_TRACE_PATTERN, b, rdata);
      total++; if (rdata !== 8'(8'h11 * (b + 1))) begin bad++; $display("FAIL shadow_readback byte%0d got=%h exp=%h", b, rdata, 8'(8'h11 * (b + 1))); end
    end
    bus_write(REG_COMMIT, 0, 8'h00);
    total++; if (O_commit_pulse !== 1'b1) begin bad++; $display("FAIL commit_pulse_hi got=%b exp=1", O_commit_pulse); end
    total++; if (O_trace_patterns[128 +: 64] !== 64'h8877665544332211) begin bad++; $display("FAIL commit_live got=%h exp=8877665544332211", O_trace_patterns[128 +: 64]); end
    @(negedge usb_clk);
    total++; if (O_commit_pulse !== 1'b0) begin bad++; $display("FAIL commit_pulse_lo got=%b exp=0", O_commit_pulse); end
  endtask

  task automatic test_back_to_back();
    @(negedge usb_clk);
    reg_address = 14'(REG_COMMIT); reg_bytecnt = '0; write_data = '0;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    @(negedge usb_clk);
    total++; if (O_commit_pulse !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b exp=1", O_commit_pulse); end
    @(negedge usb_clk);
    total++; if (O_commit_pulse !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b exp=1", O_commit_pulse); end
    reg_write = 1'b0; reg_addrvalid = 1'b0;
    @(negedge usb_clk);
    total++; if (O_commit_pulse !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", O_commit_pulse); end
  endtask

  task automatic test_enable();
    bus_write(REG_RULE_SELECT, 0, 8'd3);
    bus_write(REG_PATTERN_ENABLE, 0, 8'h01);
    bus_read(REG_PATTERN_ENABLE, 0, rdata);
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL enable_shadow got=%h exp=01", rdata); end
    total++; if (O_pattern_enable !== 8'h00) begin bad++; $display("FAIL enable_not_live got=%h exp=00", O_pattern_enable); end
    bus_write(REG_COMMIT, 0, 8'h5A);
    total++; if (O_pattern_enable !== 8'h08) begin bad++; $display("FAIL enable_live got=%h exp=08", O_pattern_enable); end
  endtask

  task automatic test_out_of_range();
    bus_write(REG_RULE_SELECT, 0, 8'd9);
    bus_read(REG_RULE_SELECT, 0, rdata);
    total++; if (rdata !== 8'd9) begin bad++; $display("FAIL sel9_readback got=%h exp=09", rdata); end
    bus_write(REG_TRACE_MASK, 0, 8'h00);
    bus_write(REG_TRACE_PATTERN, 0, 8'h55);
    bus_read(REG_TRACE_MASK, 0, rdata);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL sel9_mask_read got=%h exp=00", rdata); end
    bus_write(REG_COMMIT, 0, 8'h00);
    total++; if (O_trace_masks !== {512{1'b1}}) begin bad++; $display("FAIL sel9_masks_live got=%h exp=all ones", O_trace_masks); end
    exp_pat = '0;
    exp_pat[128 +: 64] = 64'h8877665544332211;
    total++; if (O_trace_patterns !== exp_pat) begin bad++; $display("FAIL sel9_patterns_live got=%h exp=%h", O_trace_patterns, exp_pat); end
  endtask

  task automatic test_unmapped();
    bus_write(REG_RULE_SELECT, 0, 8'd1);
    bus_write(0, 0, 8'h77);
    bus_write(10, 0, 8'h77);
    bus_read(10, 0, rdata);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL unmapped_read got=%h exp=00", rdata); end
    bus_read(REG_RULE_SELECT, 0, rdata);
    total++; if (rdata !== 8'd1) begin bad++; $display("FAIL unmapped_no_effect got=%h exp=01", rdata); end
  endtask

  task automatic test_counters();
    bus_write(REG_RULE_SELECT, 0, 8'd0);
`ifdef TRACE_COUNTERS_EN
    bus_write(REG_COUNT_CLEAR, 0, 8'hFF);
    pulse(0, 5);
    bus_read(REG_TRACE_COUNT, 0, rdata);
    total++; if (rdata !== 8'h05) begin bad++; $display("FAIL cnt_snap_b0 got=%h exp=05", rdata); end
    pulse(0, 3);
    bus_read(REG_TRACE_COUNT, 1, rdata);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL cnt_snap_b1 got=%h exp=00", rdata); end
    bus_read(REG_TRACE_COUNT, 0, rdata);
    total++; if (rdata !== 8'h08) begin bad++; $display("FAIL cnt_fresh got=%h exp=08", rdata); end
    @(negedge usb_clk);
    I_match_pulse = 8'h01;
    reg_address = 14'(REG_COUNT_CLEAR); reg_bytecnt = '0; write_data = 8'h01;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    @(negedge usb_clk);
    I_match_pulse = '0; reg_write = 1'b0; reg_addrvalid = 1'b0;
    bus_read(REG_TRACE_COUNT, 0, rdata);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL cnt_clear_wins got=%h exp=00", rdata); end
    pulse(0, 65537);
    bus_read(REG_TRACE_COUNT, 0, rdata);
    total++; if (rdata !== 8'hFF) begin bad++; $display("FAIL cnt_sat_b0 got=%h exp=ff", rdata); end
    bus_read(REG_TRACE_COUNT, 1, rdata);
    total++; if (rdata !== 8'hFF) begin bad++; $display("FAIL cnt_sat_b1 got=%h exp=ff", rdata); end
`else
    pulse(0, 3);
    bus_read(REG_TRACE_COUNT, 0, rdata);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL nocnt_read got=%h exp=00", rdata); end
    bus_write(REG_COUNT_CLEAR, 0, 8'hFF);
    bus_read(REG_TRACE_COUNT, 1, rdata);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL nocnt_read_b1 got=%h exp=00", rdata); end
`endif
  endtask

  task automatic test_async_reset();
    bus_write(REG_RULE_SELECT, 0, 8'd2);
    @(negedge usb_clk);
    reg_address = 14'(REG_TRACE_PATTERN); reg_bytecnt = '0;
    reg_read = 1'b1; reg_addrvalid = 1'b1;
    @(negedge usb_clk);
    total++; if (read_data !== 8'h11) begin bad++; $display("FAIL pre_reset_read got=%h exp=11", read_data); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (read_data !== 8'h00) begin bad++; $display("FAIL async_read_data got=%h exp=00", read_data); end
    total++; if (O_trace_patterns !== '0) begin bad++; $display("FAIL async_patterns got=%h exp=0", O_trace_patterns); end
    total++; if (O_trace_masks !== {512{1'b1}}) begin bad++; $display("FAIL async_masks got=%h exp=all ones", O_trace_masks); end
    total++; if (O_pattern_enable !== 8'h00) begin bad++; $display("FAIL async_enable got=%h exp=00", O_pattern_enable); end
    reg_read = 1'b0; reg_addrvalid = 1'b0;
    @(negedge usb_clk);
    reset_n = 1'b1;
    bus_read(REG_RULE_SELECT, 0, rdata);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL resume_select got=%h exp=00", rdata); end
    bus_read(REG_TRACE_MASK, 3, rdata);
    total++; if (rdata !== 8'hFF) begin bad++; $display("FAIL resume_mask got=%h exp=ff", rdata); end
    bus_read(REG_NUM_RULES, 0, rdata);
    total++; if (rdata !== 8'd8) begin bad++; $display("FAIL resume_num_rules got=%h exp=08", rdata); end
  endtask

  initial begin
    test_reset();
    test_params();
    test_shadow_commit();
    test_back_to_back();
    test_enable();
    test_out_of_range();
    test_unmapped();
    test_counters();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
